// File: rtl/debounce_bank.sv
// Multi-channel synchroniser + debouncer with registered press/release pulses.
// Define DEBOUNCE_BANK_AUTOREPEAT_EN to add hold-to-repeat on rise_out.
module debounce_bank #(
  parameter int   NUM_CH          = 8,
  parameter int   DEBOUNCE_CYCLES = 1000000,
  parameter int   SYNC_STAGES     = 2,
  parameter logic RESET_VAL       = 1'b0,
  parameter int   REPEAT_DELAY    = 25000000,
  parameter int   REPEAT_PERIOD   = 5000000
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic [NUM_CH-1:0] noisy_in,
  input  logic              sample_en,
  output logic [NUM_CH-1:0] clean_out,
  output logic [NUM_CH-1:0] rise_out,
  output logic [NUM_CH-1:0] fall_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

`ifdef DEBOUNCE_BANK_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DLY_MAX = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_MAX = RW'(REPEAT_PERIOD - 1);
`else
  logic unused_rep;
  assign unused_rep = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   clean_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   samp;
    logic                   mism;
    logic                   accept;
    logic                   rep_pulse;

    assign samp   = sync_q[SYNC_STAGES-1];
    assign mism   = samp != clean_q;
    assign accept = sample_en && mism && (cnt_q == CNT_MAX);

    always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
        sync_q <= {SYNC_STAGES{RESET_VAL}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_in[c]};
      end
    end

    // Any matching tick cancels progress, so only an unbroken run accepts.
    always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
        cnt_q <= '0;
      end else if (sample_en) begin
        if (!mism || accept) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
        clean_q <= RESET_VAL;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        if (accept) begin
          clean_q <= samp;
        end
        rise_q <= (accept && samp) || rep_pulse;
        fall_q <= accept && !samp;
      end
    end

`ifdef DEBOUNCE_BANK_AUTOREPEAT_EN
    logic [RW-1:0] rep_q;
    logic          armed_q;
    logic          rep_hit;

    assign rep_hit   = armed_q ? (rep_q == PER_MAX) : (rep_q == DLY_MAX);
    assign rep_pulse = sample_en && clean_q && !accept && rep_hit;

    // First hit uses the delay, later hits the period.
    always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
        rep_q   <= '0;
        armed_q <= 1'b0;
      end else if (accept || !clean_q) begin
        rep_q   <= '0;
        armed_q <= 1'b0;
      end else if (sample_en) begin
        if (rep_hit) begin
          rep_q   <= '0;
          armed_q <= 1'b1;
        end else begin
          rep_q <= rep_q + RW'(1);
        end
      end
    end
`else
    assign rep_pulse = 1'b0;
`endif

    assign clean_out[c] = clean_q;
    assign rise_out[c]  = rise_q;
    assign fall_out[c]  = fall_q;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised and directed bench for debounce_bank against a sample-history model.
module tb_debounce_bank;
  localparam int NCH = 4;
  localparam int DC  = 4;
  localparam int SS  = 2;
  localparam int RD  = 8;
  localparam int RP  = 3;
`ifdef DEBOUNCE_BANK_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sen = 1'b1;
  logic [NCH-1:0] noisy = '0;
  logic [NCH-1:0] clean, rise, fall;
  int tests = 0;
  int fails = 0;

  logic [NCH-1:0] exp_clean, exp_rise, exp_fall;
  logic hist [NCH][$];
  logic tq   [NCH][$];
  int   held [NCH];

  always #5 clk = ~clk;

  debounce_bank #(
    .NUM_CH(NCH), .DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS),
    .RESET_VAL(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock_in(clk), .reset_in(rst), .noisy_in(noisy),
    .sample_en(sen), .clean_out(clean), .rise_out(rise),
    .fall_out(fall)
  );

  // Model: pin seen SS edges late; accept when the last DC ticks all differ.
  always @(posedge clk or posedge rst) begin : model
    logic [NCH-1:0] nc, nr, nf;
    logic s;
    bit acc;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        hist[c].delete();
        tq[c].delete();
        held[c] = 0;
        for (int k = 0; k < SS; k++) hist[c].push_back(1'b0);
      end
      exp_clean <= '0;
      exp_rise  <= '0;
      exp_fall  <= '0;
    end else begin
      nc = exp_clean;
      nr = '0;
      nf = '0;
      for (int c = 0; c < NCH; c++) begin
        s = hist[c].pop_front();
        hist[c].push_back(noisy[c]);
        if (sen) begin
          tq[c].push_back(s);
          if (tq[c].size() > DC) void'(tq[c].pop_front());
          acc = (tq[c].size() == DC);
          for (int k = 0; k < tq[c].size(); k++)
            if (tq[c][k] == exp_clean[c]) acc = 1'b0;
          if (acc) begin
            nc[c] = s;
            nr[c] = s;
            nf[c] = ~s;
            tq[c].delete();
            held[c] = 0;
          end else if (exp_clean[c]) begin
            held[c]++;
            if (AR && held[c] >= RD && (held[c] - RD) % RP == 0)
              nr[c] = 1'b1;
          end
        end
      end
      exp_clean <= nc;
      exp_rise  <= nr;
      exp_fall  <= nf;
    end
  end

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({clean, rise, fall} !== 12'h000) begin
      fails++;
      $display("FAIL reset_state got %h want 000", {clean, rise, fall});
    end
    noisy = 4'hF;
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      tests++;
      if (clean !== (e == 6 ? 4'hF : 4'h0) ||
          rise !== (e == 6 ? 4'hF : 4'h0)) begin
        fails++;
        $display("FAIL reset_release e=%0d got c=%h r=%h", e, clean, rise);
      end
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({clean, rise, fall} !== 12'h000) begin
      fails++;
      $display("FAIL async_reset got %h want 000", {clean, rise, fall});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (clean !== 4'h0) begin
      fails++;
      $display("FAIL midcount_reset got %h want 0", clean);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      tests++;
      if (clean !== (e >= 6 ? 4'hF : 4'h0) ||
          rise !== (e == 6 ? 4'hF : 4'h0) || fall !== 4'h0) begin
        fails++;
        $display("FAIL restart e=%0d got c=%h r=%h f=%h", e, clean, rise, fall);
      end
    end
  endtask

  task automatic test_step();
    noisy = 4'h0;
    repeat (8) @(negedge clk);
    tests++;
    if (clean !== 4'h0) begin
      fails++;
      $display("FAIL step_pre got %h want 0", clean);
    end
    noisy = 4'h1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      tests++;
      if (clean !== (e >= 6 ? 4'h1 : 4'h0) ||
          rise !== (e == 6 ? 4'h1 : 4'h0) || fall !== 4'h0) begin
        fails++;
        $display("FAIL step e=%0d got c=%h r=%h f=%h", e, clean, rise, fall);
      end
    end
  endtask

  task automatic test_glitch();
    noisy = 4'h3;
    for (int e = 1; e <= 13; e++) begin
      if (e == 4) noisy = 4'h1;
      @(negedge clk);
      tests++;
      if (clean !== 4'h1 || rise !== 4'h0 || fall !== 4'h0) begin
        fails++;
        $display("FAIL glitch e=%0d got c=%h r=%h f=%h", e, clean, rise, fall);
      end
    end
  endtask

  task automatic test_bounce();
    int nr, nf, at;
    for (int dir = 1; dir >= 0; dir--) begin
      nr = 0;
      nf = 0;
      at = -1;
      for (int i = 0; i < 10; i++) begin
        noisy[2] = ~noisy[2];
        @(negedge clk);
        nr += int'(rise[2]);
        nf += int'(fall[2]);
      end
      noisy[2] = dir[0];
      for (int e = 1; e <= 9; e++) begin
        @(negedge clk);
        nr += int'(rise[2]);
        nf += int'(fall[2]);
        if (clean[2] === dir[0] && at < 0) at = e;
      end
      tests++;
      if (at != 6 || nr != dir || nf != 1 - dir) begin
        fails++;
        $display("FAIL bounce dir=%0d got at=%0d r=%0d f=%0d want 6", dir, at, nr, nf);
      end
    end
  endtask

  task automatic test_sample_en();
    int m = 0;
    bit tick;
    noisy[3] = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick = (e % 3 == 0);
      sen = tick;
      @(negedge clk);
      if (tick && e >= 3) m++;
      tests++;
      if (clean[3] !== (m >= 4) || rise[3] !== (tick && e == 12)) begin
        fails++;
        $display("FAIL sample_en e=%0d got c=%b r=%b", e, clean[3], rise[3]);
      end
    end
    sen = 1'b1;
  endtask

  task automatic test_repeat();
    bit want, seen;
    int nf, late;
    noisy[0] = 1'b0;
    repeat (8) @(negedge clk);
    noisy[0] = 1'b1;
    repeat (6) @(negedge clk);
    for (int k = 0; k <= 15; k++) begin
      if (k > 0) @(negedge clk);
      want = (k == 0) || (AR && (k == 8 || k == 11 || k == 14));
      tests++;
      if (rise[0] !== want || clean[0] !== 1'b1) begin
        fails++;
        $display("FAIL repeat k=%0d got r=%b c=%b want r=%b", k, rise[0], clean[0], want);
      end
    end
    noisy[0] = 1'b0;
    nf = 0;
    late = 0;
    seen = 0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (fall[0]) seen = 1;
      nf += int'(fall[0]);
      if (seen) late += int'(rise[0]);
    end
    tests++;
    if (nf != 1 || late != 0) begin
      fails++;
      $display("FAIL release falls=%0d rises_after=%0d want 1/0", nf, late);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 5) == 0) noisy[c] = ~noisy[c];
      sen = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
      tests++;
      if ({clean, rise, fall} !== {exp_clean, exp_rise, exp_fall}) begin
        fails++;
        $display("FAIL random i=%0d got %h want %h", i,
                 {clean, rise, fall}, {exp_clean, exp_rise, exp_fall});
      end
    end
    rst = 1'b0;
    sen = 1'b1;
  endtask

  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_bounce();
    test_sample_en();
    test_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
